// File: rtl/spi_pkg.sv
// Shared SPI definitions for the frame transmitter and receiver.
package spi_pkg;

  localparam int FRAME_W = 48;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one tick every CLKDIV clk cycles.
module spi_clk_div #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKDIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_frame_tx.sv
// Mode-0 SPI frame transmitter: one WIDTH-bit frame per accepted start.
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int WIDTH  = FRAME_W,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             sck,
  output logic             sdo,
  output logic             ce,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  spi_state_t       state;
  logic [WIDTH-2:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             tail;
  logic             tick;
  logic             clear;

  assign clear = (state == IDLE);

  spi_clk_div #(.CLKDIV(CLKDIV)) u_div (
    .clk    (clk),
    .nreset (nreset),
    .clear  (clear),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      sck     <= 1'b0;
      sdo     <= 1'b0;
      ce      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      tail    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          shreg   <= data[WIDTH-2:0];
          sdo     <= data[WIDTH-1];
          ce      <= 1'b1;
          busy    <= 1'b1;
          bit_cnt <= '0;
          tail    <= 1'b0;
          state   <= SETUP;
        end
        SETUP: if (tick) begin
          sck   <= 1'b1;
          state <= SHIFT_HI;
        end
        SHIFT_HI: if (tick) begin
          sck <= 1'b0;
          if (bit_cnt == LAST_BIT) begin
            state <= HOLD;
          end else begin
            sdo     <= shreg[WIDTH-2];
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: if (tick) begin
          sck   <= 1'b1;
          state <= SHIFT_HI;
        end
        // HOLD spans the trailing sck-low half-period plus the ce hold time
        HOLD: if (tick) begin
          if (!tail) begin
            tail <= 1'b1;
          end else begin
            ce    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            sdo   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench: 48-bit/div-4 and 8-bit/div-1 transmitters.
module tb_spi_frame_tx;

  logic        clk = 1'b0;
  logic [1:0]  nrst = 2'b11;
  logic [1:0]  start = 2'b00;
  logic [47:0] data_a = '0;
  logic [7:0]  data_b = '0;
  logic [1:0]  sck, sdo, ce, busy, done;

  always #5 clk = ~clk;

  spi_frame_tx u_a (
    .clk(clk), .nreset(nrst[0]), .start(start[0]), .data(data_a),
    .sck(sck[0]), .sdo(sdo[0]), .ce(ce[0]), .busy(busy[0]), .done(done[0])
  );

  spi_frame_tx #(.WIDTH(8), .CLKDIV(1)) u_b (
    .clk(clk), .nreset(nrst[1]), .start(start[1]), .data(data_b),
    .sck(sck[1]), .sdo(sdo[1]), .ce(ce[1]), .busy(busy[1]), .done(done[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wk(int k);
    return (k == 0) ? 48 : 8;
  endfunction

  function automatic int divk(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int busyk(int k);
    return divk(k) * (2 * wk(k) + 2);
  endfunction

  logic [47:0] q0[$];
  logic [47:0] q1[$];

  task automatic push(int k, logic [47:0] d);
    if (k == 0) q0.push_back(d);
    else q1.push_back({40'b0, d[7:0]});
  endtask

  // mode-0 receiver model plus protocol checks, sampled mid-cycle
  logic [47:0] cap[2];
  int          edges[2], bcnt[2], nfr[2], last_rise[2], low_run[2];
  logic [1:0]  psck = '0, psdo = '0, pbusy = '0, pce = '0;
  int          cyc = 0;
  int          qs;
  logic [47:0] expv;
  bit          b2b = 1'b0;
  int          b2b_base = 0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      cap[k] = '0; edges[k] = 0; bcnt[k] = 0;
      nfr[k] = 0; last_rise[k] = 0; low_run[k] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!nrst[k]) begin
        cap[k] = '0; edges[k] = 0; bcnt[k] = 0; low_run[k] = 0;
      end else begin
        if (sck[k] && psck[k]) chk("sdo_stable", sdo[k], psdo[k]);
        if (!ce[k]) chk("sck_low_no_ce", sck[k], 0);
        if (sck[k] && !psck[k]) begin
          if (edges[k] > 0)
            chk("sck_period", cyc - last_rise[k], 2 * divk(k));
          last_rise[k] = cyc;
          cap[k] = {cap[k][46:0], sdo[k]};
          edges[k]++;
        end
        if (busy[k]) bcnt[k]++;
        if (ce[k] && !pce[k] && k == 0 && b2b && nfr[0] > b2b_base)
          chk("ce_gap", low_run[k], 1);
        if (ce[k]) low_run[k] = 0;
        else low_run[k]++;
        if (done[k]) begin
          chk("done_after_busy", pbusy[k], 1);
          nfr[k]++;
          qs = (k == 0) ? q0.size() : q1.size();
          chk("exp_pending", qs > 0, 1);
          if (qs > 0) begin
            if (k == 0) expv = q0.pop_front();
            else expv = q1.pop_front();
            chk("frame_data", cap[k], expv);
            chk("rise_count", edges[k], wk(k));
            chk("busy_len", bcnt[k], busyk(k));
          end
          cap[k] = '0; edges[k] = 0; bcnt[k] = 0;
        end
      end
      psck[k] = sck[k]; psdo[k] = sdo[k];
      pbusy[k] = busy[k]; pce[k] = ce[k];
    end
  end

  task automatic wait_idle(int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[k] && n < 2000);
    chk("idle_timeout", busy[k], 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send(int k, logic [47:0] d);
    @(negedge clk);
    if (k == 0) data_a = d;
    else data_b = d[7:0];
    start[k] = 1'b1;
    push(k, d);
    @(negedge clk);
    start[k] = 1'b0;
    wait_idle(k);
  endtask

  int rem, npush, nb, n;
  logic [47:0] rnd;

  initial begin
    #2 nrst = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_a", {sck[0], sdo[0], ce[0], busy[0], done[0]}, 0);
    chk("rst_b", {sck[1], sdo[1], ce[1], busy[1], done[1]}, 0);
    nrst = 2'b11;
    repeat (2) @(negedge clk);

    send(0, 48'hA5A5_0F0F_1234);
    send(1, 48'h81);
    send(1, 48'h5C);

    // start held: model accepts whenever its own busy countdown is empty
    b2b = 1'b1;
    b2b_base = nfr[0];
    rem = 0;
    npush = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rem > 0) rem--;
      data_a = (i < 500) ? '1 : '0;
      start[0] = 1'b1;
      if (rem == 0) begin
        push(0, data_a);
        npush++;
        rem = busyk(0) + 1;
      end
    end
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);
    b2b = 1'b0;
    chk("b2b_frames", nfr[0] - b2b_base, npush);

    // data churns every cycle after capture
    @(negedge clk);
    rnd = {$urandom, $urandom};
    data_a = rnd;
    start[0] = 1'b1;
    push(0, rnd);
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      data_a = {$urandom, $urandom};
      @(negedge clk);
    end
    wait_idle(0);

    // random start/data on the short instance
    rem = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rem > 0) rem--;
      start[1] = 1'($urandom_range(0, 1));
      data_b = 8'($urandom);
      if (rem == 0 && start[1]) begin
        push(1, {40'b0, data_b});
        rem = busyk(1) + 1;
      end
    end
    @(negedge clk);
    start[1] = 1'b0;
    wait_idle(1);

    // abort at the 20th rising sck edge
    @(negedge clk);
    data_a = 48'h1357_9BDF_0246;
    start[0] = 1'b1;
    push(0, data_a);
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (edges[0] < 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("edge20_timeout", edges[0], 20);
    nb = nfr[0];
    nrst[0] = 1'b0;
    #1;
    chk("abort_outs", {sck[0], sdo[0], ce[0], busy[0], done[0]}, 0);
    if (q0.size() > 0) void'(q0.pop_front());
    repeat (3) @(negedge clk);
    nrst[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", nfr[0] - nb, 0);
    send(0, 48'hDEAD_BEEF_0123);

    chk("q_drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
